// File: rtl/lal_count_sched_if.sv
// Command/status bundle between the command source and the count scheduler.
// The master drives commands and keys; the slave returns registered count and status.
interface lal_count_sched_if #(
  parameter int unsigned CNT_W = 9,
  parameter int unsigned KEY_W = 4
);
  logic             start_pad;
  logic             hold_pad;
  logic             clr_pad;
  logic [CNT_W-1:0] limit_pad;
  logic [KEY_W-1:0] key_a_pad;
  logic [KEY_W-1:0] key_b_pad;
  logic [CNT_W-1:0] count_pad;
  logic             busy_pad;
  logic             done_pad;
  logic             reject_pad;
  logic             match_pad;

  modport master (
    output start_pad, hold_pad, clr_pad, limit_pad, key_a_pad, key_b_pad,
    input  count_pad, busy_pad, done_pad, reject_pad, match_pad
  );

  modport slave (
    input  start_pad, hold_pad, clr_pad, limit_pad, key_a_pad, key_b_pad,
    output count_pad, busy_pad, done_pad, reject_pad, match_pad
  );
endinterface

// File: rtl/lal_count_sched.sv
// Key-gated start, count-to-limit scheduler with hold/pause and synchronous clear.
// All outputs come straight from flops.
module lal_count_sched #(
  parameter int unsigned CNT_W = 9,
  parameter int unsigned KEY_W = 4
) (
  input logic                   clk_pad,
  input logic                   rst_pad,
  lal_count_sched_if.slave      bus
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] limit_q, limit_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             reject_q, reject_d;
  logic             match_q;
  logic             keys_eq;

  assign keys_eq = (bus.key_a_pad == bus.key_b_pad);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    limit_d  = limit_q;
    reject_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_pad) begin
          if (keys_eq) begin
            limit_d = bus.limit_pad;
            count_d = '0;
            state_d = (bus.limit_pad == '0) ? StDone : StRun;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      StRun: begin
        // clr outranks hold: a clear never diverts into PAUSE
        if (bus.clr_pad) begin
          count_d = '0;
        end else if (bus.hold_pad) begin
          state_d = StPause;
        end else begin
          count_d = count_q + CNT_W'(1);
          if (count_d == limit_q) state_d = StDone;
        end
      end
      StPause: begin
        if (bus.clr_pad)   count_d = '0;
        if (!bus.hold_pad) state_d = StRun;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    busy_d = (state_d == StRun) || (state_d == StPause);
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk_pad or posedge rst_pad) begin
    if (rst_pad) begin
      state_q  <= StIdle;
      count_q  <= '0;
      limit_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      match_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      limit_q  <= limit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      match_q  <= keys_eq;
    end
  end

  assign bus.count_pad  = count_q;
  assign bus.busy_pad   = busy_q;
  assign bus.done_pad   = done_q;
  assign bus.reject_pad = reject_q;
  assign bus.match_pad  = match_q;

endmodule

// File: tb/tb_lal_count_sched.sv
// Directed bench for lal_count_sched with hand-computed expectations.
module tb_lal_count_sched;

  localparam int unsigned CNT_W = 9;
  localparam int unsigned KEY_W = 4;

  logic clk_pad = 1'b0;
  logic rst_pad = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  lal_count_sched_if #(.CNT_W(CNT_W), .KEY_W(KEY_W)) bus ();

  lal_count_sched #(.CNT_W(CNT_W), .KEY_W(KEY_W)) dut (
    .clk_pad (clk_pad),
    .rst_pad (rst_pad),
    .bus     (bus.slave)
  );

  always #5 clk_pad = ~clk_pad;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_pad);
    #1;
  endtask

  task automatic expect_out(input string tag, input int cnt, input bit busy, input bit done);
    check_eq({tag, " count"}, 32'(bus.count_pad), 32'(cnt));
    check_eq({tag, " busy"},  32'(bus.busy_pad),  32'(busy));
    check_eq({tag, " done"},  32'(bus.done_pad),  32'(done));
  endtask

  task automatic start_cmd(input int lim, input logic [3:0] ka, input logic [3:0] kb);
    bus.limit_pad = CNT_W'(lim);
    bus.key_a_pad = ka;
    bus.key_b_pad = kb;
    bus.start_pad = 1'b1;
    tick();
    bus.start_pad = 1'b0;
  endtask

  initial begin
    bus.start_pad = 1'b0;
    bus.hold_pad  = 1'b0;
    bus.clr_pad   = 1'b0;
    bus.limit_pad = '0;
    bus.key_a_pad = '0;
    bus.key_b_pad = '0;

    // Reset values, including across a clock edge while reset is held
    #3;
    expect_out("reset", 0, 1'b0, 1'b0);
    check_eq("reset reject", 32'(bus.reject_pad), 32'd0);
    check_eq("reset match", 32'(bus.match_pad), 32'd0);
    tick();
    check_eq("reset held match", 32'(bus.match_pad), 32'd0);
    rst_pad = 1'b0;
    tick();
    check_eq("match after reset", 32'(bus.match_pad), 32'd1);

    // Normal run, limit 3
    start_cmd(3, 4'hA, 4'hA);
    expect_out("run3 c0", 0, 1'b1, 1'b0);
    tick(); expect_out("run3 c1", 1, 1'b1, 1'b0);
    tick(); expect_out("run3 c2", 2, 1'b1, 1'b0);
    tick(); expect_out("run3 done", 3, 1'b0, 1'b1);
    tick(); expect_out("run3 idle", 3, 1'b0, 1'b0);

    // Key mismatch
    start_cmd(6, 4'h5, 4'h4);
    check_eq("mismatch reject", 32'(bus.reject_pad), 32'd1);
    check_eq("mismatch match", 32'(bus.match_pad), 32'd0);
    expect_out("mismatch", 3, 1'b0, 1'b0);
    tick();
    check_eq("mismatch reject pulse", 32'(bus.reject_pad), 32'd0);
    expect_out("mismatch after", 3, 1'b0, 1'b0);

    // Hold and clear, limit 10
    start_cmd(10, 4'h3, 4'h3);
    bus.limit_pad = CNT_W'(2);  // must not affect the latched limit
    expect_out("hc c0", 0, 1'b1, 1'b0);
    repeat (4) tick();
    expect_out("hc c4", 4, 1'b1, 1'b0);
    bus.hold_pad = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("hc pause", 4, 1'b1, 1'b0);
    end
    bus.hold_pad = 1'b0;
    tick(); expect_out("hc resume", 4, 1'b1, 1'b0);
    tick(); expect_out("hc c5", 5, 1'b1, 1'b0);
    tick(); tick(); expect_out("hc c7", 7, 1'b1, 1'b0);
    bus.clr_pad  = 1'b1;
    bus.hold_pad = 1'b1;
    tick(); expect_out("hc clr", 0, 1'b1, 1'b0);
    bus.clr_pad  = 1'b0;
    bus.hold_pad = 1'b0;
    tick(); expect_out("hc clr stays run", 1, 1'b1, 1'b0);
    repeat (8) tick();
    expect_out("hc c9", 9, 1'b1, 1'b0);
    tick(); expect_out("hc done", 10, 1'b0, 1'b1);
    tick(); expect_out("hc idle", 10, 1'b0, 1'b0);

    // Asynchronous reset mid-count
    start_cmd(20, 4'h1, 4'h1);
    repeat (5) tick();
    expect_out("mid c5", 5, 1'b1, 1'b0);
    #3 rst_pad = 1'b1;
    #1 expect_out("async rst", 0, 1'b0, 1'b0);
    #1 rst_pad = 1'b0;
    tick(); expect_out("after rst", 0, 1'b0, 1'b0);
    tick(); expect_out("after rst idle", 0, 1'b0, 1'b0);

    // Limit 0
    start_cmd(0, 4'h7, 4'h7);
    expect_out("lim0 done", 0, 1'b0, 1'b1);
    tick(); expect_out("lim0 idle", 0, 1'b0, 1'b0);

    // Limit 511, no wrap
    start_cmd(511, 4'hF, 4'hF);
    repeat (510) tick();
    expect_out("lim511 c510", 510, 1'b1, 1'b0);
    tick(); expect_out("lim511 done", 511, 1'b0, 1'b1);
    tick(); expect_out("lim511 idle", 511, 1'b0, 1'b0);

    // Start held throughout a limit 2 run
    bus.limit_pad = CNT_W'(2);
    bus.start_pad = 1'b1;
    tick(); expect_out("sh c0", 0, 1'b1, 1'b0);
    tick(); expect_out("sh c1", 1, 1'b1, 1'b0);
    tick(); expect_out("sh done", 2, 1'b0, 1'b1);
    tick(); expect_out("sh idle", 2, 1'b0, 1'b0);
    tick(); expect_out("sh reaccept", 0, 1'b1, 1'b0);
    bus.start_pad = 1'b0;
    tick(); expect_out("sh re c1", 1, 1'b1, 1'b0);
    tick(); expect_out("sh re done", 2, 1'b0, 1'b1);
    tick();

    // Start and hold together in IDLE
    bus.limit_pad = CNT_W'(4);
    bus.start_pad = 1'b1;
    bus.hold_pad  = 1'b1;
    tick(); expect_out("sthd accept", 0, 1'b1, 1'b0);
    bus.start_pad = 1'b0;
    tick(); expect_out("sthd pause", 0, 1'b1, 1'b0);
    bus.hold_pad = 1'b0;
    tick(); expect_out("sthd resume", 0, 1'b1, 1'b0);
    tick(); expect_out("sthd c1", 1, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
